// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and boot status of the program loader.
// The slave modport is the loader side; the master modport is the byte source / system side.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  start;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_reset;
    logic                  load_done;
    logic                  overflow_err;
    logic [ADDR_WIDTH:0]   word_count;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, overflow_err,
               word_count
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, overflow_err,
               word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream, writes them to consecutive
// instruction-memory addresses and holds the CPU in reset until the halt word is stored.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
    typedef enum logic [1:0] {StRecv, StWrite, StDone, StError} state_e;

    localparam logic [ADDR_WIDTH-1:0] PtrOne   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CountOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [31:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StRecv;
            byte_idx_q <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            asm_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            asm_q      <= asm_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StRecv: begin
                if (bus.rx_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
                    if (byte_idx_q == 2'd3) begin
                        // Latch the write port here so it holds the last written word afterwards.
                        wdata_d    = {bus.rx_data, asm_q[23:0]};
                        addr_d     = ptr_q;
                        byte_idx_d = 2'd0;
                        state_d    = StWrite;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StWrite: begin
                count_d = count_q + CountOne;
                if (wdata_q == HALT_WORD) begin
                    state_d = StDone;
                end else if (ptr_q == '1) begin
                    state_d = StError;
                end else begin
                    ptr_d   = ptr_q + PtrOne;
                    state_d = StRecv;
                end
            end
            StDone, StError: begin
                if (bus.start) begin
                    ptr_d      = '0;
                    byte_idx_d = '0;
                    count_d    = '0;
                    asm_d      = '0;
                    state_d    = StRecv;
                end
            end
            default: state_d = StRecv;
        endcase
    end

    // Status decodes straight from state so reset drops the write strobe asynchronously.
    assign bus.rx_ready     = (state_q == StRecv);
    assign bus.imem_we      = (state_q == StWrite);
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.cpu_reset    = (state_q != StDone);
    assign bus.load_done    = (state_q == StDone);
    assign bus.overflow_err = (state_q == StError);
    assign bus.word_count   = count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: a full-size loader for load/restart/reset flows
// and a 4-word loader for the overflow path.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(8)) m_if ();
    imem_loader_if #(.ADDR_WIDTH(2)) s_if ();

    imem_loader #(.ADDR_WIDTH(8)) u_dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (m_if.slave)
    );

    imem_loader #(.ADDR_WIDTH(2)) u_small (
        .clk  (clk),
        .reset(rst_n),
        .bus  (s_if.slave)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_m[$];
    wr_t exp_s[$];
    wr_t em, es;
    int  ptr_m, ptr_s;
    int  n_checks, n_pass;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (m_if.imem_we === 1'b1) begin
            if (exp_m.size() == 0) begin
                check("m_unexpected_write", 32'(m_if.imem_addr), 32'hFFFF_FFFF);
            end else begin
                em = exp_m.pop_front();
                check("m_addr", 32'(m_if.imem_addr), 32'(em.addr));
                check("m_data", m_if.imem_wdata, em.data);
            end
        end
        if (s_if.imem_we === 1'b1) begin
            if (exp_s.size() == 0) begin
                check("s_unexpected_write", 32'(s_if.imem_addr), 32'hFFFF_FFFF);
            end else begin
                es = exp_s.pop_front();
                check("s_addr", 32'(s_if.imem_addr), 32'(es.addr));
                check("s_data", s_if.imem_wdata, es.data);
            end
        end
    end

    task automatic m_send_byte(input logic [7:0] b);
        int waited = 0;
        m_if.rx_valid = 1'b1;
        m_if.rx_data  = b;
        while (m_if.rx_ready !== 1'b1 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (m_if.rx_ready !== 1'b1) begin
            check("m_rx_ready_timeout", 32'(m_if.rx_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        m_if.rx_valid = 1'b0;
    endtask

    task automatic s_send_byte(input logic [7:0] b);
        int waited = 0;
        s_if.rx_valid = 1'b1;
        s_if.rx_data  = b;
        while (s_if.rx_ready !== 1'b1 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (s_if.rx_ready !== 1'b1) begin
            check("s_rx_ready_timeout", 32'(s_if.rx_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        s_if.rx_valid = 1'b0;
    endtask

    // Reference model: each whole word sent lands at the next word address of the load.
    task automatic m_send_word(input logic [31:0] w, input bit gaps);
        exp_m.push_back('{addr: ptr_m, data: w});
        ptr_m++;
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            m_send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic s_send_word(input logic [31:0] w);
        exp_s.push_back('{addr: ptr_s, data: w});
        ptr_s++;
        for (int k = 0; k < 4; k++) s_send_byte(w[8*k +: 8]);
    endtask

    // Called right after the halt word's last byte: one write cycle, then DONE.
    task automatic m_finish_load();
        check("m_we_after_last_byte", 32'(m_if.imem_we), 32'd1);
        check("m_cpu_reset_in_write", 32'(m_if.cpu_reset), 32'd1);
        @(posedge clk);
        #1;
        check("m_load_done", 32'(m_if.load_done), 32'd1);
        check("m_cpu_released", 32'(m_if.cpu_reset), 32'd0);
        check("m_word_count", 32'(m_if.word_count), 32'(ptr_m));
        check("m_rx_ready_done", 32'(m_if.rx_ready), 32'd0);
    endtask

    task automatic m_rearm();
        m_if.start = 1'b1;
        @(posedge clk);
        #1;
        check("m_start_cpu_reset", 32'(m_if.cpu_reset), 32'd1);
        check("m_start_rx_ready", 32'(m_if.rx_ready), 32'd1);
        check("m_start_count", 32'(m_if.word_count), 32'd0);
        m_if.start = 1'b0;
        ptr_m      = 0;
    endtask

    task automatic m_check_reset_outputs();
        check("rst_rx_ready", 32'(m_if.rx_ready), 32'd1);
        check("rst_imem_we", 32'(m_if.imem_we), 32'd0);
        check("rst_imem_addr", 32'(m_if.imem_addr), 32'd0);
        check("rst_imem_wdata", m_if.imem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(m_if.cpu_reset), 32'd1);
        check("rst_load_done", 32'(m_if.load_done), 32'd0);
        check("rst_overflow", 32'(m_if.overflow_err), 32'd0);
        check("rst_word_count", 32'(m_if.word_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog[4];
        logic [31:0] w;
        int          n;
        prog[0] = 32'h0000_0463;
        prog[1] = 32'h0040_0313;
        prog[2] = 32'h0040_0293;
        prog[3] = 32'hFFFF_FFFF;

        m_if.start = 1'b0; m_if.rx_valid = 1'b0; m_if.rx_data = 8'h00;
        s_if.start = 1'b0; s_if.rx_valid = 1'b0; s_if.rx_data = 8'h00;
        ptr_m = 0; ptr_s = 0; n_checks = 0; n_pass = 0;
        rst_n = 1'b0;
        #12;
        m_check_reset_outputs();
        check("s_rst_rx_ready", 32'(s_if.rx_ready), 32'd1);
        check("s_rst_cpu_reset", 32'(s_if.cpu_reset), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream.
        for (int i = 0; i < 4; i++) m_send_word(prog[i], 1'b0);
        m_finish_load();
        m_if.rx_valid = 1'b1;
        m_if.rx_data  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        m_if.rx_valid = 1'b0;
        check("m_done_ignores_bytes", 32'(m_if.load_done), 32'd1);
        check("m_done_count_held", 32'(m_if.word_count), 32'd4);

        // Same stream with gaps.
        m_rearm();
        for (int i = 0; i < 4; i++) m_send_word(prog[i], 1'b1);
        m_finish_load();

        // Restart with a new program.
        m_rearm();
        m_send_word(32'hDEAD_BEEF, 1'b1);
        m_send_word(32'hFFFF_FFFF, 1'b1);
        m_finish_load();

        // Random programs; odd iterations hold start high during the load.
        for (int it = 0; it < 4; it++) begin
            m_rearm();
            if (it % 2 == 1) m_if.start = 1'b1;
            n = int'($urandom_range(2, 8));
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                if (w == 32'hFFFF_FFFF) w = 32'h0;
                m_send_word(w, 1'b1);
            end
            m_send_word(32'hFFFF_FFFF, 1'b1);
            m_if.start = 1'b0;
            m_finish_load();
        end

        // Reset mid-word: word 0 written, word 1 half received.
        m_rearm();
        m_send_word(32'h0000_0013, 1'b0);
        m_send_byte(8'h78);
        m_send_byte(8'h56);
        #3;
        rst_n = 1'b0;
        #1;
        m_check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(posedge clk);
        #1;
        m_send_word(32'hFFFF_FFFF, 1'b0);
        m_finish_load();

        // Reset during the write cycle drops the strobe immediately.
        m_rearm();
        m_send_word(32'h0BAD_F00D, 1'b0);
        check("m_we_before_reset", 32'(m_if.imem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("m_we_async_drop", 32'(m_if.imem_we), 32'd0);
        check("m_count_async_clear", 32'(m_if.word_count), 32'd0);
        void'(exp_m.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(posedge clk);
        #1;

        // Overflow on the 4-word loader.
        s_send_word(32'h1111_1111);
        s_send_word(32'h2222_2222);
        s_send_word(32'h3333_3333);
        s_send_word(32'h4444_4444);
        @(posedge clk);
        #1;
        check("s_overflow_err", 32'(s_if.overflow_err), 32'd1);
        check("s_overflow_cpu_reset", 32'(s_if.cpu_reset), 32'd1);
        check("s_overflow_rx_ready", 32'(s_if.rx_ready), 32'd0);
        check("s_overflow_count", 32'(s_if.word_count), 32'd4);
        check("s_overflow_not_done", 32'(s_if.load_done), 32'd0);
        s_if.rx_valid = 1'b1;
        s_if.rx_data  = 8'h55;
        repeat (6) @(posedge clk);
        #1;
        s_if.rx_valid = 1'b0;
        check("s_error_held", 32'(s_if.overflow_err), 32'd1);
        s_if.start = 1'b1;
        @(posedge clk);
        #1;
        s_if.start = 1'b0;
        check("s_rearm_err_clear", 32'(s_if.overflow_err), 32'd0);
        check("s_rearm_rx_ready", 32'(s_if.rx_ready), 32'd1);
        check("s_rearm_count", 32'(s_if.word_count), 32'd0);

        repeat (5) @(posedge clk);
        #1;
        check("m_pending_writes", 32'(exp_m.size()), 32'd0);
        check("s_pending_writes", 32'(exp_s.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
